// File: rtl/register_file_scoreboard.sv
// Integer register file with a per-register pending-writer scoreboard.
// Decode sees operand data with write-back bypass, plus readiness that accounts for in-flight writers.
module register_file_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int PEND_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs1Addr,
  input  logic [ADDR_WIDTH-1:0] rs2Addr,
  output logic [DATA_WIDTH-1:0] rs1Data,
  output logic [DATA_WIDTH-1:0] rs2Data,
  output logic                  rs1Ready,
  output logic                  rs2Ready,
  input  logic                  prevWEnable,
  input  logic [ADDR_WIDTH-1:0] prevRdAddr,
  output logic                  allocFull,
  input  logic                  wEnable,
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  input  logic [DATA_WIDTH-1:0] wData,
  output logic                  pendOverflow,
  output logic                  pendUnderflow
);

  localparam logic [PEND_WIDTH-1:0] PEND_MAX  = {PEND_WIDTH{1'b1}};
  localparam logic [PEND_WIDTH-1:0] PEND_ZERO = {PEND_WIDTH{1'b0}};
  localparam logic [PEND_WIDTH-1:0] PEND_ONE  = {{(PEND_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] regs_q [REG_NUM];
  logic [DATA_WIDTH-1:0] regs_d [REG_NUM];
  logic [PEND_WIDTH-1:0] cnt_q  [REG_NUM];
  logic [PEND_WIDTH-1:0] cnt_d  [REG_NUM];
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  alloc_s, wb_s;
  logic [REG_NUM-1:0]    inc_s, dec_s;
  logic [ADDR_WIDTH-1:0] rs_addr_s  [2];
  logic [DATA_WIDTH-1:0] rs_data_s  [2];
  logic                  rs_ready_s [2];

  assign alloc_s = prevWEnable && (prevRdAddr != ADDR_ZERO);
  assign wb_s    = wEnable && (rdAddr != ADDR_ZERO);

  // Decode each register's increment (new writer) and decrement (write-back) request.
  always_comb begin
    inc_s = {REG_NUM{1'b0}};
    dec_s = {REG_NUM{1'b0}};
    for (int a = 0; a < REG_NUM; a++) begin
      inc_s[a] = alloc_s && (prevRdAddr == ADDR_WIDTH'(a));
      dec_s[a] = wb_s && (rdAddr == ADDR_WIDTH'(a));
    end
  end

  // Next-state for data array, saturating counters and sticky error flags.
  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (wb_s) begin
      regs_d[rdAddr] = wData;
    end else begin
      regs_d[rdAddr] = regs_q[rdAddr];
    end
    for (int a = 0; a < REG_NUM; a++) begin
      if (inc_s[a] && !dec_s[a]) begin
        if (cnt_q[a] == PEND_MAX) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d[a] = cnt_q[a] + PEND_ONE;
        end
      end else if (dec_s[a] && !inc_s[a]) begin
        // Underflow keeps the counter at zero; the data write above still lands.
        if (cnt_q[a] == PEND_ZERO) begin
          unf_d = 1'b1;
        end else begin
          cnt_d[a] = cnt_q[a] - PEND_ONE;
        end
      end else begin
        cnt_d[a] = cnt_q[a];
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < REG_NUM; a++) begin
        regs_q[a] <= {DATA_WIDTH{1'b0}};
        cnt_q[a]  <= PEND_ZERO;
      end
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign rs_addr_s[0] = rs1Addr;
  assign rs_addr_s[1] = rs2Addr;

  // Read ports: ready means cnt + pending alloc - write-back equals zero, done without negatives.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rs_data_s[p]  = {DATA_WIDTH{1'b0}};
      rs_ready_s[p] = 1'b1;
      if (rs_addr_s[p] == ADDR_ZERO) begin
        rs_data_s[p]  = {DATA_WIDTH{1'b0}};
        rs_ready_s[p] = 1'b1;
      end else begin
        if (wb_s && (rdAddr == rs_addr_s[p])) begin
          rs_data_s[p] = wData;
        end else begin
          rs_data_s[p] = regs_q[rs_addr_s[p]];
        end
        rs_ready_s[p] =
          (({1'b0, cnt_q[rs_addr_s[p]]}) +
           {{PEND_WIDTH{1'b0}}, (alloc_s && (prevRdAddr == rs_addr_s[p]))}) ==
          {{PEND_WIDTH{1'b0}}, (wb_s && (rdAddr == rs_addr_s[p]))};
      end
    end
  end

  assign rs1Data       = rs_data_s[0];
  assign rs2Data       = rs_data_s[1];
  assign rs1Ready      = rs_ready_s[0];
  assign rs2Ready      = rs_ready_s[1];
  assign allocFull     = alloc_s && (cnt_q[prevRdAddr] == PEND_MAX) &&
                         !(wb_s && (rdAddr == prevRdAddr));
  assign pendOverflow  = ovf_q;
  assign pendUnderflow = unf_q;

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Bench for register_file_scoreboard: directed vector table, async reset sequence,
// then random traffic against an integer reference model.
module tb_register_file_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rs1_addr = 5'd0, rs2_addr = 5'd0, prev_rd = 5'd0, rd_addr = 5'd0;
  logic        prev_we = 1'b0, we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_ready, rs2_ready, alloc_full, pend_ovf, pend_unf;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_reg [32];
  int m_cnt [32];
  bit m_ovf, m_unf;

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        pwe;
    logic [4:0]  prd;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [31:0] d1, d2;
    logic        r1, r2, full, ovf, unf;
  } vec_t;

  vec_t tbl [21];

  register_file_scoreboard dut (
    .clk(clk), .rst(rst),
    .rs1Addr(rs1_addr), .rs2Addr(rs2_addr),
    .rs1Data(rs1_data), .rs2Data(rs2_data),
    .rs1Ready(rs1_ready), .rs2Ready(rs2_ready),
    .prevWEnable(prev_we), .prevRdAddr(prev_rd),
    .allocFull(alloc_full),
    .wEnable(we), .rdAddr(rd_addr), .wData(wdata),
    .pendOverflow(pend_ovf), .pendUnderflow(pend_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 32; a++) begin
      m_reg[a] = 0;
      m_cnt[a] = 0;
    end
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  function automatic logic [31:0] m_data(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (we && rd_addr == a) return wdata;
    return m_reg[a];
  endfunction

  function automatic logic m_ready(input logic [4:0] a);
    int eff;
    if (a == 5'd0) return 1'b1;
    eff = m_cnt[a] + ((prev_we && prev_rd == a) ? 1 : 0) - ((we && rd_addr == a) ? 1 : 0);
    return eff == 0;
  endfunction

  function automatic logic m_full();
    if (!prev_we || prev_rd == 5'd0) return 1'b0;
    return (m_cnt[prev_rd] == 3) && !(we && rd_addr == prev_rd);
  endfunction

  task automatic model_edge();
    for (int a = 1; a < 32; a++) begin
      int n = m_cnt[a] + ((prev_we && prev_rd == a) ? 1 : 0) - ((we && rd_addr == a) ? 1 : 0);
      if (n > 3) begin n = 3; m_ovf = 1'b1; end
      if (n < 0) begin n = 0; m_unf = 1'b1; end
      m_cnt[a] = n;
    end
    if (we && rd_addr != 5'd0) m_reg[rd_addr] = wdata;
  endtask

  task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic pw,
                       input logic [4:0] pr, input logic w, input logic [4:0] rd,
                       input logic [31:0] wd);
    @(negedge clk);
    rs1_addr = r1; rs2_addr = r2; prev_we = pw; prev_rd = pr;
    we = w; rd_addr = rd; wdata = wd;
    #1;
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_edge();
  endtask

  initial begin
    model_reset();
    //            rs1    rs2    pwe   prd    we    rd     wd            d1            d2         r1    r2    full  ovf   unf
    tbl[0]  = '{5'd5,  5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  32'h0,        32'h0,        32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{5'd7,  5'd0, 1'b1, 5'd7, 1'b0, 5'd0,  32'h0,        32'h0,        32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{5'd7,  5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  32'h0,        32'h0,        32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{5'd7,  5'd0, 1'b0, 5'd0, 1'b1, 5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{5'd7,  5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  32'h0,        32'hDEADBEEF, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{5'd7,  5'd3, 1'b1, 5'd3, 1'b0, 5'd0,  32'h0,        32'hDEADBEEF, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{5'd7,  5'd3, 1'b1, 5'd3, 1'b0, 5'd0,  32'h0,        32'hDEADBEEF, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{5'd7,  5'd3, 1'b0, 5'd0, 1'b1, 5'd3,  32'h33,       32'hDEADBEEF, 32'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{5'd7,  5'd3, 1'b0, 5'd0, 1'b1, 5'd3,  32'h34,       32'hDEADBEEF, 32'h34, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{5'd9,  5'd3, 1'b1, 5'd9, 1'b0, 5'd0,  32'h0,        32'h0,        32'h34, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{5'd9,  5'd3, 1'b1, 5'd9, 1'b1, 5'd9,  32'h99,       32'h99,       32'h34, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{5'd9,  5'd4, 1'b0, 5'd0, 1'b0, 5'd0,  32'h0,        32'h99,       32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{5'd9,  5'd4, 1'b1, 5'd4, 1'b0, 5'd0,  32'h0,        32'h99,       32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{5'd9,  5'd4, 1'b1, 5'd4, 1'b0, 5'd0,  32'h0,        32'h99,       32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{5'd9,  5'd4, 1'b1, 5'd4, 1'b0, 5'd0,  32'h0,        32'h99,       32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{5'd9,  5'd4, 1'b1, 5'd4, 1'b0, 5'd0,  32'h0,        32'h99,       32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{5'd9,  5'd4, 1'b0, 5'd0, 1'b0, 5'd0,  32'h0,        32'h99,       32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{5'd0,  5'd4, 1'b0, 5'd0, 1'b1, 5'd0,  32'h1234,     32'h0,        32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[18] = '{5'd0,  5'd4, 1'b0, 5'd0, 1'b1, 5'd12, 32'hC0FFEE,   32'h0,        32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[19] = '{5'd12, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0,  32'h0,        32'hC0FFEE,   32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[20] = '{5'd12, 5'd4, 1'b1, 5'd4, 1'b1, 5'd4,  32'h44,       32'hC0FFEE,   32'h44, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // hold reset across a couple of edges, then release away from the edge
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].rs1, tbl[i].rs2, tbl[i].pwe, tbl[i].prd, tbl[i].we, tbl[i].rd, tbl[i].wd);
      check($sformatf("vec%0d.rs1Data", i),  rs1_data,   tbl[i].d1);
      check($sformatf("vec%0d.rs2Data", i),  rs2_data,   tbl[i].d2);
      check($sformatf("vec%0d.rs1Ready", i), {31'd0, rs1_ready},  {31'd0, tbl[i].r1});
      check($sformatf("vec%0d.rs2Ready", i), {31'd0, rs2_ready},  {31'd0, tbl[i].r2});
      check($sformatf("vec%0d.allocFull", i), {31'd0, alloc_full}, {31'd0, tbl[i].full});
      check($sformatf("vec%0d.ovf", i),      {31'd0, pend_ovf},   {31'd0, tbl[i].ovf});
      check($sformatf("vec%0d.unf", i),      {31'd0, pend_unf},   {31'd0, tbl[i].unf});
      finish_cycle();
    end

    // asynchronous reset in the middle of a cycle, no clock edge in between
    drive(5'd9, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    check("prerst.rs1Data", rs1_data, 32'h99);
    check("prerst.rs2Ready", {31'd0, rs2_ready}, 32'd0);
    #1 rst = 1'b0;
    #1;
    check("rst.rs1Data",  rs1_data, 32'h0);
    check("rst.rs2Data",  rs2_data, 32'h0);
    check("rst.rs1Ready", {31'd0, rs1_ready}, 32'd1);
    check("rst.rs2Ready", {31'd0, rs2_ready}, 32'd1);
    check("rst.allocFull", {31'd0, alloc_full}, 32'd0);
    check("rst.ovf", {31'd0, pend_ovf}, 32'd0);
    check("rst.unf", {31'd0, pend_unf}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // random traffic on a small address window so collisions are frequent
    for (int c = 0; c < 600; c++) begin
      drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            32'($urandom));
      check("rnd.rs1Data", rs1_data, m_data(rs1_addr));
      check("rnd.rs2Data", rs2_data, m_data(rs2_addr));
      check("rnd.rs1Ready", {31'd0, rs1_ready}, {31'd0, m_ready(rs1_addr)});
      check("rnd.rs2Ready", {31'd0, rs2_ready}, {31'd0, m_ready(rs2_addr)});
      check("rnd.allocFull", {31'd0, alloc_full}, {31'd0, m_full()});
      check("rnd.ovf", {31'd0, pend_ovf}, {31'd0, m_ovf});
      check("rnd.unf", {31'd0, pend_unf}, {31'd0, m_unf});
      finish_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
